// File: rtl/intensity_link.sv
// -----------------------------------------------------------------------------
// intensity_link
//
// Debounces the 4-bit intensity level from the distance block, stamps every
// committed change with a wrapping 4-bit sequence number, and serves the most
// recent {seq, level} byte to a microcontroller through a mode-0 SPI slave.
// The SPI pins are oversampled by the 40 MHz system clock; no logic runs on sck.
//
// Ports:
//   clk        system clock (40 MHz)
//   reset      asynchronous, active-low reset
//   intensity  level from the distance block, synchronous to clk
//   sck        SPI clock from the MCU, idle low, asynchronous to clk
//   cs_n       SPI chip select from the MCU, active low, asynchronous to clk
//   sdo        SPI data to the MCU, MSB first, driven 0 while deselected
//   ready      high while a committed update has not yet been read
//
// ready/read handshake: ready rises on the clk edge that commits a new level
// and falls on the edge that detects a falling cs_n (the start of a read). A
// commit landing on that same edge wins, so an update is never lost. Any
// frame start counts as a read, even if the frame is later aborted.
// -----------------------------------------------------------------------------
module intensity_link #(
    parameter int STABLE_CYCLES = 400000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] intensity,
    input  logic       sck,
    input  logic       cs_n,
    output logic       sdo,
    output logic       ready
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Debounce and commit
    // ------------------------------------------------------------------
    logic [3:0]       candidate;
    logic [3:0]       committed;
    logic [3:0]       seq;
    logic [CNT_W-1:0] stable_cnt;
    logic             commit;

    // The counter saturates, so "equal to max" is the same as "not below
    // STABLE_CYCLES-1". A candidate equal to the committed value is held but
    // never re-committed, so returning to the old level does not bump seq.
    assign commit = (intensity == candidate) && (stable_cnt == CNT_MAX) &&
                    (candidate != committed);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            candidate  <= '0;
            stable_cnt <= '0;
            committed  <= '0;
            seq        <= '0;
        end else begin
            if (intensity != candidate) begin
                candidate  <= intensity;
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
            if (commit) begin
                committed <= candidate;
                seq       <= seq + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // SPI pin synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_prev;
    logic                   cs_prev;
    logic                   sck_s;
    logic                   cs_s;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sck_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Idle bus levels, so a cs_n held low across reset release is
            // seen as a fresh frame start.
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_prev <= 1'b0;
            cs_prev  <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_prev <= sck_s;
            cs_prev  <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;
    assign sck_fall = sck_prev & ~sck_s & ~cs_s;

    // ------------------------------------------------------------------
    // SPI shifter. sdo carries the current bit; shift_reg holds the seven
    // bits still to be sent, MSB-aligned. The snapshot is taken from the
    // registered seq/committed, i.e. the pre-commit frame if a commit lands
    // on the cs_fall edge.
    // ------------------------------------------------------------------
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            sdo       <= 1'b0;
        end else if (cs_fall) begin
            shift_reg <= {seq[2:0], committed};
            sdo       <= seq[3];
            bit_cnt   <= '0;
        end else if (cs_rise) begin
            sdo     <= 1'b0;
            bit_cnt <= '0;
        end else if (sck_fall) begin
            if (bit_cnt != 3'd7) begin
                sdo       <= shift_reg[6];
                shift_reg <= {shift_reg[5:0], 1'b0};
                bit_cnt   <= bit_cnt + 3'd1;
            end else begin
                // Clocks past the eighth bit read zeros.
                sdo <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Update-pending flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready <= 1'b0;
        end else if (commit) begin
            ready <= 1'b1;
        end else if (cs_fall) begin
            ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_intensity_link.sv
module tb_intensity_link;

    localparam int S  = 8;
    localparam int SS = 2;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [3:0] intensity = 4'h0;
    logic       sck       = 1'b0;
    logic       cs_n      = 1'b1;
    logic       sdo;
    logic       ready;

    intensity_link #(
        .STABLE_CYCLES(S),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .intensity(intensity),
        .sck      (sck),
        .cs_n     (cs_n),
        .sdo      (sdo),
        .ready    (ready)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / counters ----------------
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A level commits when the last S+1 samples since reset are all the same
    // value and that value differs from the committed one. cs_n is seen by the
    // block SS samples late; a frame starts where that delayed view goes 1->0.
    logic [3:0] m_committed = 4'h0;
    logic [3:0] m_seq       = 4'h0;
    logic       m_ready     = 1'b0;
    logic [3:0] in_hist[$];
    bit         cs_hist[$];

    always @(posedge clk) begin
        bit commit_now;
        bit cur_cs;
        bit prv_cs;
        if (!reset) begin
            m_committed = 4'h0;
            m_seq       = 4'h0;
            m_ready     = 1'b0;
            in_hist.delete();
            cs_hist.delete();
            exp_q.delete();
        end else begin
            in_hist.push_back(intensity);
            if (in_hist.size() > S + 1) void'(in_hist.pop_front());
            cs_hist.push_back(cs_n);
            if (cs_hist.size() > SS + 2) void'(cs_hist.pop_front());

            commit_now = (in_hist.size() == S + 1);
            for (int i = 1; i <= S; i++)
                if (commit_now && in_hist[i] != in_hist[0]) commit_now = 0;
            if (commit_now && in_hist[S] == m_committed) commit_now = 0;

            cur_cs = (cs_hist.size() >= SS + 1) ? cs_hist[cs_hist.size() - 1 - SS] : 1'b1;
            prv_cs = (cs_hist.size() >= SS + 2) ? cs_hist[cs_hist.size() - 2 - SS] : 1'b1;

            if (prv_cs && !cur_cs) begin
                exp_q.push_back({m_seq, m_committed});
                if (!commit_now) m_ready = 1'b0;
            end
            if (commit_now) begin
                m_committed = in_hist[S];
                m_seq       = m_seq + 4'd1;
                m_ready     = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        bit quiet;
        #1;
        check("ready", {15'd0, ready}, {15'd0, m_ready});
        quiet = (cs_hist.size() == SS + 2);
        foreach (cs_hist[i]) if (!cs_hist[i]) quiet = 0;
        if (!reset || quiet) check("sdo_idle", {15'd0, sdo}, 16'd0);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame of nbits clocks at clk/8; compares against the snapshot
    // the model captured at the frame start.
    task automatic spi_frame(input int nbits, output logic [7:0] got);
        logic [7:0] want;
        logic [7:0] mask;
        logic [1:0] tail;
        int         nb;
        got  = 8'h00;
        tail = 2'b00;
        cs_n = 1'b0;
        step(SS + 3);
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b1;
            if (i < 8) got[7 - i] = sdo;
            else tail[i - 8] = sdo;
            step(4);
            sck = 1'b0;
            step(4);
        end
        cs_n = 1'b1;
        step(6);
        nb = (nbits < 8) ? nbits : 8;
        if (exp_q.size() == 0) begin
            check("frame_missing", 16'd1, 16'd0);
        end else begin
            want = exp_q.pop_front();
            mask = 8'hFF << (8 - nb);
            check("frame", {8'd0, got & mask}, {8'd0, want & mask});
        end
        if (nbits > 8) check("frame_tail", {14'd0, tail}, 16'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [7:0] got;
        int         es;
        logic [3:0] v;

        @(negedge clk);
        step(3);
        reset = 1'b1;
        step(5);

        // 1: reset mid-stream, then first commit and read
        intensity = 4'h9;
        step(4);
        reset = 1'b0;
        step(3);
        check("t1_reset_ready", {15'd0, ready}, 16'd0);
        check("t1_reset_sdo", {15'd0, sdo}, 16'd0);
        reset = 1'b1;
        step(S);
        check("t1_before_commit", {15'd0, ready}, 16'd0);
        step(1);
        check("t1_commit", {15'd0, ready}, 16'd1);
        check("t1_model_seq", {12'd0, m_seq}, 16'd1);
        spi_frame(8, got);
        check("t1_byte", {8'd0, got}, 16'h19);
        check("t1_ready_cleared", {15'd0, ready}, 16'd0);

        // 2: toggling input never commits; final value commits after S cycles
        for (int k = 0; k < 19; k++) begin
            intensity = (k % 2 == 0) ? 4'h3 : 4'h4;
            step(5);
        end
        check("t2_no_commit", {12'd0, m_seq}, 16'd1);
        intensity = 4'h4;
        step(S);
        check("t2_before_commit", {15'd0, ready}, 16'd0);
        step(1);
        check("t2_commit", {15'd0, ready}, 16'd1);
        step(20);
        check("t2_hold_seq", {12'd0, m_seq}, 16'd2);
        spi_frame(8, got);
        check("t2_byte", {8'd0, got}, 16'h24);

        // 3: short excursion back to the committed value
        intensity = 4'h6;
        step(7);
        intensity = 4'h4;
        step(20);
        check("t3_ready", {15'd0, ready}, 16'd0);
        spi_frame(8, got);
        check("t3_byte", {8'd0, got}, 16'h24);

        // 4: sequence number wraps
        es = 2;
        for (int k = 0; k < 17; k++) begin
            v = (k % 2 == 1) ? 4'h5 : 4'h2;
            intensity = v;
            step(S + 3);
            es = (es + 1) % 16;
            spi_frame(8, got);
            check("t4_byte", {8'd0, got}, {8'd0, es[3:0], v});
        end

        // 5: commit while a frame is in flight
        fork
            spi_frame(8, got);
            begin
                step(SS + 3 + 3 * 8);
                intensity = 4'hB;
            end
        join
        check("t5_old_byte", {8'd0, got}, 16'h32);
        check("t5_ready_set", {15'd0, ready}, 16'd1);
        spi_frame(8, got);
        check("t5_new_byte", {8'd0, got}, 16'h4B);

        // 6: frame start on the same edge as a commit, with extra clocks
        intensity = 4'h7;
        step(S - SS);
        spi_frame(10, got);
        check("t6_old_byte", {8'd0, got}, 16'h4B);
        check("t6_ready_kept", {15'd0, ready}, 16'd1);
        spi_frame(8, got);
        check("t6_new_byte", {8'd0, got}, 16'h57);
        check("t6_ready_cleared", {15'd0, ready}, 16'd0);

        // random: level changes and reads of random length overlap freely
        fork
            begin
                int c;
                int h;
                c = 0;
                while (c < 3000) begin
                    case ($urandom_range(0, 3))
                        0:       intensity = 4'h1;
                        1:       intensity = 4'h7;
                        2:       intensity = 4'hC;
                        default: intensity = 4'($urandom_range(0, 15));
                    endcase
                    h = $urandom_range(1, 14);
                    step(h);
                    c += h;
                end
            end
            begin
                logic [7:0] rgot;
                repeat (25) begin
                    step($urandom_range(0, 30));
                    spi_frame($urandom_range(1, 10), rgot);
                end
            end
        join
        step(10);
        check("no_stray_frames", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
